// File: rtl/j0_arb_pkg.sv
// rtl/j0_arb_pkg.sv - shared types and defaults for the J0 data-RAM arbiter
package j0_arb_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    J0_RD = 2'd1,
    HOST  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_J0   = 2'd1,
    GNT_HOST = 2'd2
  } gnt_e;

endpackage

// File: rtl/j0_arb_pick.sv
// rtl/j0_arb_pick.sv - combinational grant picker; rr_ptr_i=1 favours the J0 on a tie
module j0_arb_pick
  import j0_arb_pkg::*;
(
  input  logic j0_req_i,
  input  logic host_req_i,
  input  logic rr_ptr_i,
  output gnt_e gnt_o
);

  always_comb begin
    gnt_o = GNT_NONE;
    if (j0_req_i && host_req_i) begin
      gnt_o = rr_ptr_i ? GNT_J0 : GNT_HOST;
    end else if (j0_req_i) begin
      gnt_o = GNT_J0;
    end else if (host_req_i) begin
      gnt_o = GNT_HOST;
    end
  end

endmodule

// File: rtl/j0_mem_arbiter.sv
// rtl/j0_mem_arbiter.sv - J0/host single-port RAM arbiter with J0 stall generation
// J0_ARB_RR_EN selects round-robin arbitration; otherwise the host has fixed priority.
module j0_mem_arbiter
  import j0_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              j0_mem_rd,
  input  logic              j0_mem_wr,
  input  logic [ADDR_W-1:0] j0_mem_addr,
  input  logic [DATA_W-1:0] j0_mem_dout,
  output logic [DATA_W-1:0] j0_mem_din,
  output logic              j0_pause,
  input  logic              j0_halt,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e            state_q, state_d;
  gnt_e              gnt;
  logic              j0_req;
  logic              rr_ptr;
  logic [DATA_W-1:0] j0_din_q;
  logic [DATA_W-1:0] host_rdata_q;

  assign j0_req = (j0_mem_rd | j0_mem_wr) & ~j0_halt;

`ifdef J0_ARB_RR_EN
  logic rr_q, rr_d;

  // Pointer only moves on contested grants, so a lone requester never shifts the balance.
  assign rr_d   = rr_q ^ ((state_q == IDLE) & j0_req & host_req);
  assign rr_ptr = rr_q;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  assign rr_ptr = 1'b0;
`endif

  j0_arb_pick u_pick (
    .j0_req_i   (j0_req),
    .host_req_i (host_req),
    .rr_ptr_i   (rr_ptr),
    .gnt_o      (gnt)
  );

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q      <= IDLE;
      j0_din_q     <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == J0_RD) begin
        j0_din_q <= ram_rdata;
      end
      if ((state_q == HOST) && !host_wr) begin
        host_rdata_q <= ram_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt == GNT_HOST) begin
          state_d = HOST;
        end else if ((gnt == GNT_J0) && j0_mem_rd) begin
          state_d = J0_RD;
        end
      end
      J0_RD:   state_d = IDLE;
      HOST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data is passed straight through in the completion cycle and held afterwards.
  always_comb begin
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = j0_mem_addr;
    ram_wdata  = j0_mem_dout;
    j0_pause   = 1'b0;
    host_ack   = 1'b0;
    j0_mem_din = j0_din_q;
    host_rdata = host_rdata_q;
    case (state_q)
      IDLE: begin
        case (gnt)
          GNT_J0: begin
            ram_en   = 1'b1;
            ram_we   = ~j0_mem_rd;
            j0_pause = j0_mem_rd;
          end
          GNT_HOST: begin
            ram_en    = 1'b1;
            ram_we    = host_wr;
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
            j0_pause  = j0_req;
          end
          default: ;
        endcase
        if (j0_halt) begin
          j0_pause = 1'b1;
        end
      end
      J0_RD: begin
        j0_mem_din = ram_rdata;
        if (j0_mem_wr) begin
          ram_en = 1'b1;
          ram_we = 1'b1;
        end
      end
      HOST: begin
        host_ack = 1'b1;
        if (!host_wr) begin
          host_rdata = ram_rdata;
        end
        j0_pause = j0_mem_rd | j0_mem_wr | j0_halt;
      end
      default: ;
    endcase
    if (sys_rst_i) begin
      ram_en     = 1'b0;
      ram_we     = 1'b0;
      host_ack   = 1'b0;
      j0_pause   = 1'b1;
      j0_mem_din = '0;
      host_rdata = '0;
    end
  end

endmodule

// File: tb/tb_j0_mem_arbiter.sv
// tb/tb_j0_mem_arbiter.sv - directed self-checking bench for j0_mem_arbiter
module tb_j0_mem_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          j0_rd, j0_wr, j0_halt, j0_pause;
  logic [AW-1:0] j0_addr;
  logic [DW-1:0] j0_dout, j0_din;
  logic          host_req, host_wr, host_ack;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  j0_mem_arbiter dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst),
    .j0_mem_rd   (j0_rd),
    .j0_mem_wr   (j0_wr),
    .j0_mem_addr (j0_addr),
    .j0_mem_dout (j0_dout),
    .j0_mem_din  (j0_din),
    .j0_pause    (j0_pause),
    .j0_halt     (j0_halt),
    .host_req    (host_req),
    .host_wr     (host_wr),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_ack    (host_ack),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  task automatic drive(input logic r, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic h, input logic hr, input logic hw,
                       input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    @(negedge clk);
    rst = r; j0_rd = rd; j0_wr = wr; j0_addr = a; j0_dout = d; j0_halt = h;
    host_req = hr; host_wr = hw; host_addr = ha; host_wdata = hd;
    #1;
  endtask

  task automatic test_reset;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (j0_pause !== 1'b1) begin n_fail++; $display("FAIL rst_pause: got %0h want 1", j0_pause); end
    n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en: got %0h want 0", ram_en); end
    n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %0h want 0", host_ack); end
    n_checks++; if (host_rdata !== 16'h0) begin n_fail++; $display("FAIL rst_host_rdata: got %0h want 0", host_rdata); end
    n_checks++; if (j0_din !== 16'h0) begin n_fail++; $display("FAIL rst_j0_din: got %0h want 0", j0_din); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (j0_pause !== 1'b0) begin n_fail++; $display("FAIL idle_pause: got %0h want 0", j0_pause); end
    n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL idle_ram_en: got %0h want 0", ram_en); end
  endtask

  task automatic test_host_rw;
    drive(0, 0, 0, 0, 0, 0, 1, 1, 15'h10, 16'h1234);
    n_checks++; if ({ram_en, ram_we} !== 2'b11) begin n_fail++; $display("FAIL hw_ram_en_we: got %0b want 11", {ram_en, ram_we}); end
    n_checks++; if (ram_addr !== 15'h10) begin n_fail++; $display("FAIL hw_ram_addr: got %0h want 10", ram_addr); end
    n_checks++; if (ram_wdata !== 16'h1234) begin n_fail++; $display("FAIL hw_ram_wdata: got %0h want 1234", ram_wdata); end
    n_checks++; if ({host_ack, j0_pause} !== 2'b00) begin n_fail++; $display("FAIL hw_grant_ack_pause: got %0b want 00", {host_ack, j0_pause}); end
    drive(0, 0, 0, 0, 0, 0, 1, 1, 15'h10, 16'h1234);
    n_checks++; if ({host_ack, ram_en, j0_pause} !== 3'b100) begin n_fail++; $display("FAIL hw_ack_cycle: got %0b want 100", {host_ack, ram_en, j0_pause}); end
    drive(0, 0, 0, 0, 0, 0, 1, 0, 15'h10, 16'h0);
    n_checks++; if ({ram_en, ram_we, host_ack} !== 3'b100) begin n_fail++; $display("FAIL hr_grant: got %0b want 100", {ram_en, ram_we, host_ack}); end
    drive(0, 0, 0, 0, 0, 0, 1, 0, 15'h10, 16'h0);
    n_checks++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL hr_ack: got %0h want 1", host_ack); end
    n_checks++; if (host_rdata !== 16'h1234) begin n_fail++; $display("FAIL hr_rdata: got %0h want 1234", host_rdata); end
    n_checks++; if (j0_pause !== 1'b0) begin n_fail++; $display("FAIL hr_pause: got %0h want 0", j0_pause); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if ({host_ack, ram_en} !== 2'b00) begin n_fail++; $display("FAIL hr_after: got %0b want 00", {host_ack, ram_en}); end
    n_checks++; if (host_rdata !== 16'h1234) begin n_fail++; $display("FAIL hr_hold: got %0h want 1234", host_rdata); end
  endtask

  task automatic test_j0_read;
    drive(0, 1, 0, 15'h10, 0, 0, 0, 0, 0, 0);
    n_checks++; if ({j0_pause, ram_en, ram_we} !== 3'b110) begin n_fail++; $display("FAIL jr_issue: got %0b want 110", {j0_pause, ram_en, ram_we}); end
    n_checks++; if (ram_addr !== 15'h10) begin n_fail++; $display("FAIL jr_addr: got %0h want 10", ram_addr); end
    drive(0, 1, 0, 15'h10, 0, 0, 0, 0, 0, 0);
    n_checks++; if (j0_pause !== 1'b0) begin n_fail++; $display("FAIL jr_done_pause: got %0h want 0", j0_pause); end
    n_checks++; if (j0_din !== 16'h1234) begin n_fail++; $display("FAIL jr_din: got %0h want 1234", j0_din); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if ({j0_pause, ram_en} !== 2'b00) begin n_fail++; $display("FAIL jr_after: got %0b want 00", {j0_pause, ram_en}); end
    n_checks++; if (j0_din !== 16'h1234) begin n_fail++; $display("FAIL jr_hold: got %0h want 1234", j0_din); end
  endtask

  task automatic test_j0_rmw;
    drive(0, 0, 1, 15'h20, 16'hAAAA, 0, 0, 0, 0, 0);
    n_checks++; if ({j0_pause, ram_en, ram_we} !== 3'b011) begin n_fail++; $display("FAIL jw_issue: got %0b want 011", {j0_pause, ram_en, ram_we}); end
    drive(0, 1, 1, 15'h20, 16'h5555, 0, 0, 0, 0, 0);
    n_checks++; if ({j0_pause, ram_en, ram_we} !== 3'b110) begin n_fail++; $display("FAIL rmw_read: got %0b want 110", {j0_pause, ram_en, ram_we}); end
    drive(0, 1, 1, 15'h20, 16'h5555, 0, 0, 0, 0, 0);
    n_checks++; if (j0_din !== 16'hAAAA) begin n_fail++; $display("FAIL rmw_old_data: got %0h want aaaa", j0_din); end
    n_checks++; if ({j0_pause, ram_en, ram_we} !== 3'b011) begin n_fail++; $display("FAIL rmw_write: got %0b want 011", {j0_pause, ram_en, ram_we}); end
    n_checks++; if (ram_wdata !== 16'h5555) begin n_fail++; $display("FAIL rmw_wdata: got %0h want 5555", ram_wdata); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 15'h20, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 15'h20, 0);
    n_checks++; if ({host_ack, host_rdata} !== {1'b1, 16'h5555}) begin n_fail++; $display("FAIL rmw_new_data: got ack %0h data %0h want ack 1 data 5555", host_ack, host_rdata); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_contention;
    int seq [8];
    int ng = 0;
    int nack = 0;
    int pause_bad = 0;
    int exp_g, exp_ack;
    for (int c = 0; c < 16; c++) begin
      drive(0, 1, 0, 15'h10, 0, 0, 1, 0, 15'h20, 0);
      if (ram_en && !ram_we && ng < 8) begin
        seq[ng] = (ram_addr == 15'h20) ? 2 : 1;
        ng++;
      end
      if (host_ack) nack++;
`ifndef J0_ARB_RR_EN
      if (j0_pause !== 1'b1) pause_bad++;
`endif
    end
    n_checks++; if (ng !== 8) begin n_fail++; $display("FAIL ct_grant_count: got %0d want 8", ng); end
    for (int i = 0; i < ng; i++) begin
`ifdef J0_ARB_RR_EN
      exp_g = (i % 2 == 0) ? 2 : 1;
`else
      exp_g = 2;
`endif
      n_checks++; if (seq[i] !== exp_g) begin n_fail++; $display("FAIL ct_grant_%0d: got %0d want %0d (1=j0 2=host)", i, seq[i], exp_g); end
    end
`ifdef J0_ARB_RR_EN
    exp_ack = 4;
`else
    exp_ack = 8;
`endif
    n_checks++; if (nack !== exp_ack) begin n_fail++; $display("FAIL ct_ack_count: got %0d want %0d", nack, exp_ack); end
    n_checks++; if (pause_bad !== 0) begin n_fail++; $display("FAIL ct_starved_pause: got %0d unpaused cycles want 0", pause_bad); end
    drive(0, 1, 0, 15'h10, 0, 0, 0, 0, 15'h20, 0);
    n_checks++; if ({ram_en, ram_we, j0_pause} !== 3'b101) begin n_fail++; $display("FAIL ct_j0_after_drop: got %0b want 101", {ram_en, ram_we, j0_pause}); end
    n_checks++; if (ram_addr !== 15'h10) begin n_fail++; $display("FAIL ct_j0_addr: got %0h want 10", ram_addr); end
    drive(0, 1, 0, 15'h10, 0, 0, 0, 0, 0, 0);
    n_checks++; if ({j0_pause, j0_din} !== {1'b0, 16'h1234}) begin n_fail++; $display("FAIL ct_j0_done: got pause %0h din %0h want pause 0 din 1234", j0_pause, j0_din); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_halt;
    drive(0, 1, 0, 15'h20, 0, 0, 0, 0, 0, 0);
    n_checks++; if ({j0_pause, ram_en, ram_addr} !== {2'b11, 15'h20}) begin n_fail++; $display("FAIL ht_issue: got pause %0h en %0h addr %0h", j0_pause, ram_en, ram_addr); end
    drive(0, 1, 0, 15'h20, 0, 1, 0, 0, 0, 0);
    n_checks++; if ({j0_pause, j0_din} !== {1'b0, 16'h5555}) begin n_fail++; $display("FAIL ht_inflight: got pause %0h din %0h want pause 0 din 5555", j0_pause, j0_din); end
    for (int c = 0; c < 2; c++) begin
      drive(0, 1, 0, 15'h20, 0, 1, 0, 0, 0, 0);
      n_checks++; if ({j0_pause, ram_en} !== 2'b10) begin n_fail++; $display("FAIL ht_frozen_%0d: got %0b want 10", c, {j0_pause, ram_en}); end
    end
    drive(0, 1, 0, 15'h20, 0, 1, 1, 0, 15'h10, 0);
    n_checks++; if ({j0_pause, ram_en, ram_addr} !== {2'b11, 15'h10}) begin n_fail++; $display("FAIL ht_host_grant: got pause %0h en %0h addr %0h", j0_pause, ram_en, ram_addr); end
    drive(0, 1, 0, 15'h20, 0, 1, 1, 0, 15'h10, 0);
    n_checks++; if ({host_ack, j0_pause, host_rdata} !== {2'b11, 16'h1234}) begin n_fail++; $display("FAIL ht_host_ack: got ack %0h pause %0h data %0h", host_ack, j0_pause, host_rdata); end
    drive(0, 1, 0, 15'h20, 0, 1, 0, 0, 0, 0);
    n_checks++; if ({j0_pause, ram_en} !== 2'b10) begin n_fail++; $display("FAIL ht_after_host: got %0b want 10", {j0_pause, ram_en}); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (j0_pause !== 1'b0) begin n_fail++; $display("FAIL ht_release: got %0h want 0", j0_pause); end
  endtask

  task automatic test_reset_in_host;
    drive(0, 0, 0, 0, 0, 0, 1, 1, 15'h40, 16'h7777);
    n_checks++; if ({ram_en, ram_we} !== 2'b11) begin n_fail++; $display("FAIL rh_write: got %0b want 11", {ram_en, ram_we}); end
    drive(1, 0, 0, 0, 0, 0, 1, 1, 15'h40, 16'h7777);
    n_checks++; if ({host_ack, j0_pause, ram_en} !== 3'b010) begin n_fail++; $display("FAIL rh_abort: got %0b want 010", {host_ack, j0_pause, ram_en}); end
    drive(1, 0, 0, 0, 0, 0, 1, 1, 15'h40, 16'h7777);
    n_checks++; if ({host_ack, j0_pause, ram_en} !== 3'b010) begin n_fail++; $display("FAIL rh_held: got %0b want 010", {host_ack, j0_pause, ram_en}); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if ({j0_pause, ram_en, host_ack} !== 3'b000) begin n_fail++; $display("FAIL rh_idle: got %0b want 000", {j0_pause, ram_en, host_ack}); end
    n_checks++; if ({j0_din, host_rdata} !== 32'h0) begin n_fail++; $display("FAIL rh_cleared: got din %0h rdata %0h want 0 0", j0_din, host_rdata); end
    drive(0, 0, 0, 0, 0, 0, 1, 0, 15'h40, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 15'h40, 0);
    n_checks++; if ({host_ack, host_rdata} !== {1'b1, 16'h7777}) begin n_fail++; $display("FAIL rh_write_stands: got ack %0h data %0h want ack 1 data 7777", host_ack, host_rdata); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; j0_rd = 1'b0; j0_wr = 1'b0; j0_addr = '0; j0_dout = '0; j0_halt = 1'b0;
    host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
    test_reset();
    test_host_rw();
    test_j0_read();
    test_j0_rmw();
    test_contention();
    test_halt();
    test_reset_in_host();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
